// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage: register bank, constant extender, writeback mux, ID/EX register
//
// Purpose:
//   Reads two source operands from the register bank and extends the raw
//   immediate. It captures both operands, the extended constant and the
//   destination in an ID/EX register that uses a valid/ready handshake.
//   When the instruction held in ID/EX is a load whose destination matches
//   an incoming source, the stage inserts a one-cycle bubble (load-use stall).
//   The writeback mux result drives the register bank write port.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a same-cycle write to a register being read is forwarded
//   (write-through). When undefined, reads see the old stored value.
//
// Ports:
//   clock, reset_n           - clock, synchronous active-low reset
//   in_valid/in_ready        - incoming decoded instruction handshake
//   sel_a, sel_b, sel_c      - source A, source B, destination register
//   constante, ext_mode      - raw immediate, 1 = sign / 0 = zero extend
//   in_is_load               - incoming instruction is a load
//   flush                    - kill ID/EX contents
//   wb_en, wb_addr, wb_sel   - register write enable/address, result select
//   ula, md, pc              - ALU, memory and PC writeback sources
//   wb_data                  - selected writeback value (combinational)
//   out_valid/out_ready      - ID/EX handshake towards EX
//   out_a, out_b, out_const  - registered operands and extended constant
//   out_dest, out_is_load    - registered destination and load flag
//   hazard                   - load-use stall active (combinational)

module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int CONST_W  = 16,
  parameter int PC_INC   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_AW-1:0]  sel_a,
  input  logic [REG_AW-1:0]  sel_b,
  input  logic [REG_AW-1:0]  sel_c,
  input  logic [CONST_W-1:0] constante,
  input  logic               ext_mode,
  input  logic               in_is_load,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [1:0]         wb_sel,
  input  logic [DATA_W-1:0]  ula,
  input  logic [DATA_W-1:0]  md,
  input  logic [DATA_W-1:0]  pc,
  output logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [DATA_W-1:0]  out_const,
  output logic [REG_AW-1:0]  out_dest,
  output logic               out_is_load,
  output logic               hazard
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] stored_a, stored_b;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] const_ext;
  logic              advance;
  logic              accept;

  // Writeback mux; PC+PC_INC wraps naturally at DATA_W bits.
  always_comb begin
    wb_data = ula;
    case (wb_sel)
      2'b00: wb_data = ula;
      2'b01: wb_data = md;
      2'b10: wb_data = pc;
      2'b11: wb_data = pc + DATA_W'(PC_INC);
      default: wb_data = ula;
    endcase
  end

  // Addresses past the last register read as zero.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    if (int'(sel_a) < NUM_REGS) stored_a = regs[sel_a];
    if (int'(sel_b) < NUM_REGS) stored_b = regs[sel_b];
  end

`ifdef WB_BYPASS_EN
  assign rd_a = (wb_en && wb_addr == sel_a) ? wb_data : stored_a;
  assign rd_b = (wb_en && wb_addr == sel_b) ? wb_data : stored_b;
`else
  assign rd_a = stored_a;
  assign rd_b = stored_b;
`endif

  // Upper bits are zero in zero-extend mode and copy the constant MSB in sign-extend mode.
  assign const_ext = {{(DATA_W-CONST_W){ext_mode & constante[CONST_W-1]}}, constante};

  assign hazard   = out_valid & out_is_load & in_valid &
                    ((out_dest == sel_a) | (out_dest == sel_b));
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance & !hazard;
  assign accept   = advance & in_valid & !hazard;

  // Register bank; writes to addresses past the last register are dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && int'(wb_addr) < NUM_REGS) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ID/EX register. Flush wins over capture. A bubble clears only the valid
  // flag, and the data fields keep their previous values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_const   <= '0;
      out_dest    <= '0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_a       <= rd_a;
      out_b       <= rd_b;
      out_const   <= const_ext;
      out_dest    <= sel_c;
      out_is_load <= in_is_load;
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe

module tb_id_stage_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic [15:0] constante;
  logic        ext_mode;
  logic        in_is_load;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [1:0]  wb_sel;
  logic [31:0] ula, md, pc;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b, out_const;
  logic [3:0]  out_dest;
  logic        out_is_load;
  logic        hazard;

  int checks   = 0;
  int failures = 0;

  id_stage_pipe dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .sel_c       (sel_c),
    .constante   (constante),
    .ext_mode    (ext_mode),
    .in_is_load  (in_is_load),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_sel      (wb_sel),
    .ula         (ula),
    .md          (md),
    .pc          (pc),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_const   (out_const),
    .out_dest    (out_dest),
    .out_is_load (out_is_load),
    .hazard      (hazard)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; sel_a = '0; sel_b = '0; sel_c = '0;
    constante = '0; ext_mode = 1'b0; in_is_load = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_sel = 2'b00; ula = '0; md = '0; pc = '0;
    out_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_a", out_a, 32'd0);

    // write reg3 = 0xDEAD, read it back through out_a
    wb_en = 1'b1; wb_addr = 4'd3; wb_sel = 2'b00; ula = 32'h0000_DEAD;
    #1 chk("wb_sel_ula", wb_data, 32'h0000_DEAD);
    tick();
    wb_en = 1'b0; in_valid = 1'b1; sel_a = 4'd3;
    tick();
    chk("reg3_written", out_a, 32'h0000_DEAD);
    chk("accept_valid", {31'b0, out_valid}, 32'd1);

    // reset for 2 cycles clears the bank and the ID/EX register
    in_valid = 1'b0; reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_out_a", out_a, 32'd0);
    in_valid = 1'b1; sel_a = 4'd3;
    tick();
    chk("reg3_after_rst", out_a, 32'd0);

    // extender
    constante = 16'h8001; ext_mode = 1'b1;
    tick();
    chk("sext_neg", out_const, 32'hFFFF_8001);
    ext_mode = 1'b0;
    tick();
    chk("zext_neg", out_const, 32'h0000_8001);
    constante = 16'h7FFF; ext_mode = 1'b1;
    tick();
    chk("sext_pos", out_const, 32'h0000_7FFF);

    // writeback select, including PC+4 wrap into reg5
    in_valid = 1'b0;
    md = 32'hA5A5_0001; pc = 32'hFFFF_FFFE;
    wb_sel = 2'b01; #1 chk("wb_sel_md", wb_data, 32'hA5A5_0001);
    wb_sel = 2'b10; #1 chk("wb_sel_pc", wb_data, 32'hFFFF_FFFE);
    wb_sel = 2'b11; #1 chk("wb_sel_pcinc", wb_data, 32'h0000_0002);
    wb_en = 1'b1; wb_addr = 4'd5;
    tick();
    wb_en = 1'b0; in_valid = 1'b1; sel_a = 4'd0; sel_b = 4'd5;
    tick();
    chk("reg5_wrap", out_b, 32'h0000_0002);

    // load-use: load to r7, then consumer of r7
    sel_a = 4'd0; sel_b = 4'd0; sel_c = 4'd7; in_is_load = 1'b1;
    tick();
    chk("load_valid", {31'b0, out_valid}, 32'd1);
    chk("load_flag", {31'b0, out_is_load}, 32'd1);
    sel_a = 4'd7; sel_c = 4'd8; in_is_load = 1'b0;
    #1;
    chk("hazard_on", {31'b0, hazard}, 32'd1);
    chk("hazard_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("bubble_valid", {31'b0, out_valid}, 32'd0);
    chk("bubble_dest_held", {28'b0, out_dest}, 32'd7);
    chk("hazard_cleared", {31'b0, hazard}, 32'd0);
    chk("in_ready_after", {31'b0, in_ready}, 32'd1);
    tick();
    chk("consumer_valid", {31'b0, out_valid}, 32'd1);
    chk("consumer_dest", {28'b0, out_dest}, 32'd8);

    // backpressure for 3 cycles, then flush with in_valid still high
    out_ready = 1'b0; sel_a = 4'd1; sel_c = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_dest", {28'b0, out_dest}, 32'd8);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; out_ready = 1'b1;

    // bypass: reg2 = 0x1111, then write 0x1234 while reading reg2
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd2; wb_sel = 2'b00; ula = 32'h0000_1111;
    tick();
    ula = 32'h0000_1234; in_valid = 1'b1; sel_a = 4'd2; sel_b = 4'd0;
    tick();
`ifdef WB_BYPASS_EN
    chk("bypass_a", out_a, 32'h0000_1234);
`else
    chk("bypass_a", out_a, 32'h0000_1111);
`endif
    wb_en = 1'b0;
    tick();
    chk("reg2_after", out_a, 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
